seq_detect_ctrl: RTL and testbench
==================================

SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 Parameters SHALL be: `PAT_W`, default 8, maximum pattern length in bits; `CNT_W`, default 16, width of the match counter; `TIMEOUT_BITS`, default 64, valid-bit timeout limit.
REQ-002 Ports SHALL be: `clk`  in  1  sole clock, rising edge.
REQ-003 `rst`  in  1  reset; synchronous, active-high.
REQ-004 `cfg_we`  in  1  config write strobe; honoured only in IDLE.
REQ-005 `cfg_pattern`  in  PAT_W  target pattern; bit0 is the last-received bit.
REQ-006 `cfg_len`  in  4  pattern length; 0 or values above PAT_W are treated as PAT_W.
REQ-007 `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-008 `cfg_max`  in  8  match limit that ends a run; 0 = unlimited.
REQ-009 `start`, `stop`  in  1 each  run control pulses.
REQ-010 `din`, `din_valid`  in  1 each  serial data bit and its qualifier.
REQ-011 `irq_clr`  in  1  clears `irq`.
REQ-012 `match`  out  1  one-cycle detection pulse.
REQ-013 `busy`  out  1  high in RUN only.
REQ-014 `done`  out  1  high in DONE only.
REQ-015 `match_count`  out  CNT_W  matches in the current run.
REQ-016 `irq`  out  1  sticky completion flag.
REQ-017 `timeout`  out  1  sticky flag: the run ended by timeout.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 In IDLE, `cfg_we` SHALL latch `cfg_pattern`, `cfg_len`, `cfg_overlap` and `cfg_max`; `cfg_we` in RUN or DONE SHALL be ignored.
REQ-020 `start` in IDLE or DONE SHALL enter RUN and clear the history register, fill count, `match_count`, `irq`, `timeout` and the timeout counter.
REQ-021 `stop` in RUN SHALL return to IDLE without setting `irq`; when `start` and `stop` are both high in RUN, `stop` SHALL win.
REQ-022 In RUN, each cycle with `din_valid`=1 SHALL shift `din` into bit0 of the history and increment the fill count, saturating at PAT_W.
REQ-023 Cycles with `din_valid`=0 SHALL leave history, fill count and counters unchanged.
REQ-024 A match SHALL occur when fill count >= len and the low len history bits equal the low len pattern bits, both evaluated after the shift.
REQ-025 `match` SHALL be registered and assert exactly in the cycle after the sampling edge (latency 1).
REQ-026 On a match with `cfg_overlap`=0, the fill count SHALL reset to 0; with `cfg_overlap`=1, the history SHALL be retained.
REQ-027 `match_count` SHALL increment on each match and saturate at all-ones.
REQ-028 When `cfg_max`!=0 and `match_count` reaches `cfg_max`, the FSM SHALL enter DONE and set `irq` in the same cycle as the final `match` pulse.
REQ-029 In DONE, `din` SHALL be ignored and `match_count` held; DONE SHALL be left only by `start` or `rst`.
REQ-030 `irq` SHALL stay set until `irq_clr`; when set and clear coincide, set SHALL win.
REQ-031 `irq_clr` SHALL NOT change the FSM state.
REQ-032 `match` SHALL never assert outside RUN, except on the final-match cycle that enters DONE.

Reset
REQ-033 `rst` SHALL force IDLE and clear every output to 0.
REQ-034 `rst` SHALL load config with pattern 0, len PAT_W, overlap 1 and max 0.
REQ-035 `rst` SHALL override every other input in the same cycle, including mid-run, and any in-flight `match` SHALL be dropped.

Configuration
REQ-036 Macro `SEQ_DETECT_CTRL_TIMEOUT_EN` SHALL compile the timeout feature in or out.
REQ-037 When defined, a counter of valid bits since `start` or since the last match SHALL run in RUN.
REQ-038 When that counter reaches `TIMEOUT_BITS`, the FSM SHALL enter DONE and set both `timeout` and `irq`.
REQ-039 When the macro is undefined, no timeout counter SHALL exist and `timeout` SHALL be tied to 0.

Structure
REQ-040 Package `seq_detect_pkg` SHALL hold the state enum (IDLE, RUN, DONE), PAT_W and CNT_W defaults, and the length-clamp function.
REQ-041 Sub-module `seq_match_core` SHALL contain the history shift register, fill count and compare, and expose only `hit`.
REQ-042 The FSM, counters and flags SHALL live in the top module.

Verification
REQ-043 Overlap: pattern 1101, len 4, overlap 1, max 0; stream 01101110101101101 all valid -> `match` pulses after bits 4, 8, 13 and 16; `match_count`=4.
REQ-044 Non-overlap: pattern 101, len 3; stream 10101 -> 2 matches with overlap=1, 1 match (after bit 2) with overlap=0.
REQ-045 Limit: max=2 with the REQ-043 stream -> DONE and `irq`=1 after bit 8; later bits cause no `match`; `irq_clr` drops `irq` while `done` stays 1.
REQ-046 Gaps: the REQ-043 stream with `din_valid`=0 inserted between every bit -> identical matches, each delayed accordingly; `cfg_we` during RUN leaves the pattern unchanged.
REQ-047 Reset/stop: `rst` one cycle after the 3rd bit of 1101 -> IDLE, all outputs 0; `start`+`stop` together in RUN -> IDLE.
REQ-048 Timeout (macro defined, TIMEOUT_BITS=16): 16 valid zeros after `start` -> DONE with `timeout`=1 and `irq`=1; with the macro undefined -> still RUN, `timeout`=0.

Source files
------------

// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_pkg
// Description : Shared types and helpers for the serial sequence detector:
//               FSM state encoding, default widths and the length clamp.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

   localparam int c_PAT_W_DEF = 8;
   localparam int c_CNT_W_DEF = 16;

   // Explicit 2-bit encoding; the fourth code is unreachable and recovers to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // A length of 0, or one longer than the pattern register, means "use all of it".
   function automatic int unsigned clamp_len(input logic [3:0] len, input int unsigned pat_w);
      if ((len == 4'd0) || (32'(len) > pat_w)) begin
         return pat_w;
      end
      return 32'(len);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_match_core.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_core
// Description : Bit-serial history shift register with fill count and masked
//               compare against the target pattern. Reports a hit on the
//               cycle a shifted-in bit completes the pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_core
   import seq_detect_pkg::*;
#(
   parameter int PAT_W  = c_PAT_W_DEF,
   parameter int FILL_W = $clog2(PAT_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              shift,
   input  logic              din,
   input  logic [PAT_W-1:0]  pattern,
   input  logic [FILL_W-1:0] len,
   input  logic              overlap,
   output logic              hit
);

   logic [PAT_W-1:0]  r_hist;
   logic [PAT_W-1:0]  w_hist_next;
   logic [PAT_W-1:0]  w_mask;
   logic [FILL_W-1:0] r_fill;
   logic [FILL_W-1:0] w_fill_next;

   // Newest bit enters at bit0; the fill count saturates once the register is full.
   assign w_hist_next = (r_hist << 1) | PAT_W'(din);
   assign w_fill_next = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + 1'b1;

   // Mask selecting the low len bits that take part in the compare.
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         w_mask[i] = (FILL_W'(i) < len);
      end
   end

   // Compare uses the post-shift view so the hit lines up with the bit just taken.
   assign hit = shift && (w_fill_next >= len) &&
                ((w_hist_next & w_mask) == (pattern & w_mask));

   // History and fill update; non-overlapping mode restarts filling after a hit.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_hist <= '0;
         r_fill <= '0;
      end else if (shift) begin
         r_hist <= w_hist_next;
         r_fill <= (hit && !overlap) ? '0 : w_fill_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Serial sequence detector controller. IDLE/RUN/DONE FSM,
//               config latch, match counter with optional limit, sticky irq.
//               Optional valid-bit timeout compiled in by defining
//               SEQ_DETECT_CTRL_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int PAT_W        = c_PAT_W_DEF,
   parameter int CNT_W        = c_CNT_W_DEF,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [3:0]       cfg_len,
   input  logic             cfg_overlap,
   input  logic [7:0]       cfg_max,
   input  logic             start,
   input  logic             stop,
   input  logic             din,
   input  logic             din_valid,
   input  logic             irq_clr,
   output logic             match,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_count,
   output logic             irq,
   output logic             timeout
);

   localparam int c_FILL_W = $clog2(PAT_W + 1);

   // A timeout limit below one would end every run before any data arrives.
   if (TIMEOUT_BITS < 1) begin : g_timeout_bits_chk
      $error("TIMEOUT_BITS must be at least 1");
   end

   state_t             r_state;
   state_t             w_state_next;
   logic [PAT_W-1:0]   r_pattern;
   logic [c_FILL_W-1:0] r_len;
   logic               r_overlap;
   logic [7:0]         r_max;
   logic               r_match;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   w_count_inc;
   logic               r_irq;
   logic               w_start;
   logic               w_shift;
   logic               w_hit;
   logic               w_max_hit;
   logic               w_to_hit;

   // start is only meaningful outside RUN; inside RUN stop has priority.
   assign w_start     = start && (r_state != RUN);
   assign w_shift     = (r_state == RUN) && din_valid && !stop;
   assign w_count_inc = (&r_count) ? r_count : r_count + 1'b1;
   assign w_max_hit   = w_hit && (r_max != 8'd0) && (w_count_inc == CNT_W'(r_max));

   // Config is latched in IDLE only so a run always sees a stable pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pattern <= '0;
         r_len     <= c_FILL_W'(PAT_W);
         r_overlap <= 1'b1;
         r_max     <= 8'd0;
      end else if (cfg_we && (r_state == IDLE)) begin
         r_pattern <= cfg_pattern;
         r_len     <= c_FILL_W'(clamp_len(cfg_len, PAT_W));
         r_overlap <= cfg_overlap;
         r_max     <= cfg_max;
      end
   end

   seq_match_core #(
      .PAT_W  (PAT_W),
      .FILL_W (c_FILL_W)
   ) u_core (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_start),
      .shift   (w_shift),
      .din     (din),
      .pattern (r_pattern),
      .len     (r_len),
      .overlap (r_overlap),
      .hit     (w_hit)
   );

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
   localparam int c_TO_W = $clog2(TIMEOUT_BITS + 1);

   logic [c_TO_W-1:0] r_to_cnt;
   logic              r_timeout;

   // Fires on the valid bit that brings the count since start/last match to the limit.
   assign w_to_hit = w_shift && !w_hit && (r_to_cnt == c_TO_W'(TIMEOUT_BITS - 1));

   // Valid-bit counter since start or the most recent match.
   always_ff @(posedge clk) begin
      if (rst || w_start) begin
         r_to_cnt <= '0;
      end else if (w_shift) begin
         r_to_cnt <= w_hit ? '0 : r_to_cnt + 1'b1;
      end
   end

   // Sticky record that the run ended by timeout.
   always_ff @(posedge clk) begin
      if (rst || w_start) begin
         r_timeout <= 1'b0;
      end else if (w_to_hit) begin
         r_timeout <= 1'b1;
      end
   end

   assign timeout = r_timeout;
`else
   assign w_to_hit = 1'b0;
   assign timeout  = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN: begin
            if (stop)                        w_state_next = IDLE;
            else if (w_max_hit || w_to_hit)  w_state_next = DONE;
         end
         DONE:    if (start) w_state_next = RUN;
         default: w_state_next = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy = (r_state == RUN);
      done = (r_state == DONE);
   end

   // Match pulse is the registered hit, one cycle after the sampling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_match <= 1'b0;
      end else begin
         r_match <= w_hit;
      end
   end

   // Saturating match counter, cleared at the start of each run.
   always_ff @(posedge clk) begin
      if (rst || w_start) begin
         r_count <= '0;
      end else if (w_hit) begin
         r_count <= w_count_inc;
      end
   end

   // Sticky completion flag; a set in the same cycle as irq_clr takes priority.
   always_ff @(posedge clk) begin
      if (rst || w_start) begin
         r_irq <= 1'b0;
      end else if (w_max_hit || w_to_hit) begin
         r_irq <= 1'b1;
      end else if (irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign match       = r_match;
   assign match_count = r_count;
   assign irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_ctrl
// Description : Self-checking bench for seq_detect_ctrl. Directed streams push
//               expected matches into a scoreboard; a monitor pops and
//               compares on every match pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;

   localparam int PAT_W        = 8;
   localparam int CNT_W        = 16;
   localparam int TIMEOUT_BITS = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [3:0]       cfg_len;
   logic             cfg_overlap;
   logic [7:0]       cfg_max;
   logic             start;
   logic             stop;
   logic             din;
   logic             din_valid;
   logic             irq_clr;
   logic             match;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_count;
   logic             irq;
   logic             timeout;

   always #5 clk = ~clk;

   seq_detect_ctrl #(
      .PAT_W        (PAT_W),
      .CNT_W        (CNT_W),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_max     (cfg_max),
      .start       (start),
      .stop        (stop),
      .din         (din),
      .din_valid   (din_valid),
      .irq_clr     (irq_clr),
      .match       (match),
      .busy        (busy),
      .done        (done),
      .match_count (match_count),
      .irq         (irq),
      .timeout     (timeout)
   );

   typedef struct {
      int   idx;
      int   cnt;
      logic irq;
   } exp_t;

   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   int   bits_sent = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every match pulse must correspond to the oldest expected entry.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (match === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_match: got match at bit %0d expected none", bits_sent - 1);
         end else begin
            e = sb.pop_front();
            check("match_bit", bits_sent - 1, e.idx);
            check("match_count_at_match", match_count, e.cnt);
            check("irq_at_match", irq, e.irq);
         end
      end
   end

   task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] mx);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = ov;
      cfg_max     = mx;
      cfg_we      = 1'b1;
      @(negedge clk);
      cfg_we      = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   // bits: first character is the first bit sent; exp: '1' where a match is due.
   task automatic send_stream(input string bits, input string exp, input int irq_idx, input bit gaps);
      int cnt = 0;
      bits_sent = 0;
      for (int i = 0; i < bits.len(); i++) begin
         if (exp[i] == "1") begin
            cnt++;
            sb.push_back('{idx: i, cnt: cnt, irq: logic'(i == irq_idx)});
         end
         din       = (bits[i] == "1");
         din_valid = 1'b1;
         bits_sent++;
         @(negedge clk);
         din_valid = 1'b0;
         if (gaps) @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_match"}, match, 0);
      check({tag, "_count"}, match_count, 0);
      check({tag, "_irq"}, irq, 0);
      check({tag, "_timeout"}, timeout, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = 4'd0; cfg_overlap = 1'b0;
      cfg_max = 8'd0; start = 1'b0; stop = 1'b0; din = 1'b0; din_valid = 1'b0; irq_clr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_all_zero("reset");

      // Reset config: pattern 0, full length, overlapping.
      pulse_start();
      check("reset_cfg_busy", busy, 1);
      send_stream("000000000", "000000011", -1, 1'b0);
      check("reset_cfg_count", match_count, 2);
      pulse_stop();
      check("stop_busy", busy, 0);

      // Overlapping detection of 1101.
      cfg(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      pulse_start();
      send_stream("01101110101101101", "00001000100001001", -1, 1'b0);
      check("overlap_count", match_count, 4);
      check("overlap_busy", busy, 1);
      pulse_stop();

      // 101 over 10101, overlap then non-overlap.
      cfg(8'b0000_0101, 4'd3, 1'b1, 8'd0);
      pulse_start();
      send_stream("10101", "00101", -1, 1'b0);
      check("ov101_count", match_count, 2);
      pulse_stop();
      cfg(8'b0000_0101, 4'd3, 1'b0, 8'd0);
      pulse_start();
      send_stream("10101", "00100", -1, 1'b0);
      check("nov101_count", match_count, 1);
      pulse_stop();

      // Match limit of 2.
      cfg(8'b0000_1101, 4'd4, 1'b1, 8'd2);
      pulse_start();
      send_stream("01101110101101101", "00001000100000000", 8, 1'b0);
      check("limit_done", done, 1);
      check("limit_busy", busy, 0);
      check("limit_irq", irq, 1);
      check("limit_count", match_count, 2);
      irq_clr = 1'b1;
      @(negedge clk);
      irq_clr = 1'b0;
      check("irqclr_irq", irq, 0);
      check("irqclr_done", done, 1);
      pulse_start();
      check("restart_busy", busy, 1);
      check("restart_count", match_count, 0);
      pulse_stop();

      // Gapped stream; config write while running must be ignored.
      cfg(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      pulse_start();
      cfg(8'b0000_0000, 4'd2, 1'b0, 8'd1);
      send_stream("01101110101101101", "00001000100001001", -1, 1'b1);
      check("gaps_count", match_count, 4);
      check("gaps_busy", busy, 1);
      pulse_stop();

      // Reset in the cycle that would complete 1101.
      cfg(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      pulse_start();
      bits_sent = 0;
      din_valid = 1'b1;
      din = 1'b1; bits_sent++; @(negedge clk);
      din = 1'b1; bits_sent++; @(negedge clk);
      din = 1'b0; bits_sent++; @(negedge clk);
      din = 1'b1; bits_sent++; rst = 1'b1; @(negedge clk);
      rst = 1'b0;
      din_valid = 1'b0;
      check_all_zero("midrun_rst");
      @(negedge clk);
      check("midrun_rst_match_late", match, 0);

      // start and stop together while running.
      pulse_start();
      check("ss_pre_busy", busy, 1);
      start = 1'b1;
      stop  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b0;
      check("ss_busy", busy, 0);
      check("ss_done", done, 0);

      // Sixteen valid zeros with no match.
      cfg(8'b0000_1101, 4'd4, 1'b1, 8'd0);
      pulse_start();
      send_stream("0000000000000000", "0000000000000000", -1, 1'b0);
`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
      check("to_done", done, 1);
      check("to_busy", busy, 0);
      check("to_timeout", timeout, 1);
      check("to_irq", irq, 1);
`else
      check("to_busy", busy, 1);
      check("to_timeout", timeout, 0);
      check("to_irq", irq, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
